// File: rtl/nec_pkg.sv
// nec_pkg
// Shared types and constants for the NEC V-series test-socket bus controller.
//   bus_state_t       : bus-cycle FSM states
//   nec_addr_t        : 20-bit byte address as latched from the AD/A pins
//   READ_TIMEOUT_DATA : value returned to the CPU when a read is never acknowledged
package nec_pkg;

  typedef enum logic [2:0] {IDLE, ADDR, REQ, WAIT, END} bus_state_t;

  typedef logic [19:0] nec_addr_t;

  localparam logic [15:0] READ_TIMEOUT_DATA = 16'hFFFF;

endpackage

// File: rtl/nec_clk_gen.sv
// nec_clk_gen
// Divides clk_sys down to the NEC CPU clock and produces single-cycle strobes
// marking the clk_sys cycle in which nec_clk changes level.
// Ports:
//   clk_sys  : system clock
//   reset    : asynchronous, active-high reset (nec_clk starts low)
//   nec_clk  : CPU clock, CLK_DIV clk_sys cycles per period, 50% duty
//   clk_rise : high in the cycle whose closing edge drives nec_clk 0 -> 1
//   clk_fall : high in the cycle whose closing edge drives nec_clk 1 -> 0
module nec_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_sys,
  input  logic reset,
  output logic nec_clk,
  output logic clk_rise,
  output logic clk_fall
);

  localparam int HALF = CLK_DIV / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = (cnt == CW'(HALF - 1));

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      nec_clk <= 1'b0;
    end else if (wrap) begin
      cnt     <= '0;
      nec_clk <= ~nec_clk;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Strobes are asserted in the cycle before the toggle so that logic acting
  // on them updates on the same clk_sys edge that moves nec_clk.
  assign clk_rise = wrap & ~nec_clk;
  assign clk_fall = wrap & nec_clk;

endmodule

// File: rtl/nec_bus_ctrl.sv
// nec_bus_ctrl
// Clock and bus-cycle controller for the NEC V-series CPU test socket.
// Generates the CPU clock, latches the address on ASTB, decodes memory/I/O
// reads and writes, hands each data cycle to a clk_sys-domain memory port
// through a req/ack handshake, stretches the cycle with READY wait states and
// controls the AD level-shifter direction and output enable.
// Ports:
//   clk_sys, reset                  : system clock, async active-high reset
//   wait_states                     : extra NEC clocks of READY low, sampled at ASTB
//   nec_clk, nec_ready              : CPU clock and READY
//   nec_ad_in                       : AD/A pins as seen by the FPGA
//   nec_ad_out, nec_ad_oe           : read data onto AD[15:0] and its enable
//   nec_ad_dir                      : level-shifter direction, 1 = FPGA to CPU
//   nec_astb/rdn/wrn/ion/uben       : raw CPU strobes
//   mem_req/we/io/addr/be/wdata     : memory port request side
//   mem_rdata, mem_ack              : memory port response side
//   timeout_err                     : one-cycle pulse on an unacknowledged request
module nec_bus_ctrl
  import nec_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int WAIT_W  = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [WAIT_W-1:0] wait_states,
  output logic              nec_clk,
  output logic              nec_ready,
  input  logic [19:0]       nec_ad_in,
  output logic [15:0]       nec_ad_out,
  output logic              nec_ad_oe,
  output logic              nec_ad_dir,
  input  logic              nec_astb,
  input  logic              nec_rdn,
  input  logic              nec_wrn,
  input  logic              nec_ion,
  input  logic              nec_uben,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_io,
  output logic [19:0]       mem_addr,
  output logic [1:0]        mem_be,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              timeout_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  // Strobe idle levels {astb, rdn, wrn, ion, uben}: ASTB low, the rest high.
  localparam logic [4:0] STROBE_IDLE = 5'b01111;

  logic clk_fall;
  logic unused_clk_rise;

  nec_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .nec_clk  (nec_clk),
    .clk_rise (unused_clk_rise),
    .clk_fall (clk_fall)
  );

  logic [4:0] sync1, sync2;
  logic       astb_d;
  logic       astb_s, rdn_s, wrn_s, ion_s, uben_s, astb_fall;

  // Two-flop synchronisers; reset to idle levels so no edge appears at reset release.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sync1  <= STROBE_IDLE;
      sync2  <= STROBE_IDLE;
      astb_d <= 1'b0;
    end else begin
      sync1  <= {nec_astb, nec_rdn, nec_wrn, nec_ion, nec_uben};
      sync2  <= sync1;
      astb_d <= sync2[4];
    end
  end

  assign {astb_s, rdn_s, wrn_s, ion_s, uben_s} = sync2;
  assign astb_fall = astb_d & ~astb_s;

  bus_state_t        state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic [TW-1:0]     to_cnt, to_nxt;
  logic              ube, ube_nxt;
  logic              is_read, is_read_nxt;
  logic              end_rel, end_rel_nxt;
  logic              ready_nxt, oe_nxt, dir_nxt, req_nxt, we_nxt, io_nxt, to_err_nxt;
  logic [19:0]       addr_nxt;
  logic [1:0]        be_nxt;
  logic [15:0]       wdata_nxt, ad_out_nxt;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      to_cnt      <= '0;
      ube         <= 1'b0;
      is_read     <= 1'b0;
      end_rel     <= 1'b0;
      nec_ready   <= 1'b1;
      nec_ad_oe   <= 1'b0;
      nec_ad_dir  <= 1'b0;
      nec_ad_out  <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_io      <= 1'b0;
      mem_addr    <= '0;
      mem_be      <= '0;
      mem_wdata   <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_nxt;
      to_cnt      <= to_nxt;
      ube         <= ube_nxt;
      is_read     <= is_read_nxt;
      end_rel     <= end_rel_nxt;
      nec_ready   <= ready_nxt;
      nec_ad_oe   <= oe_nxt;
      nec_ad_dir  <= dir_nxt;
      nec_ad_out  <= ad_out_nxt;
      mem_req     <= req_nxt;
      mem_we      <= we_nxt;
      mem_io      <= io_nxt;
      mem_addr    <= addr_nxt;
      mem_be      <= be_nxt;
      mem_wdata   <= wdata_nxt;
      timeout_err <= to_err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    wait_nxt    = wait_cnt;
    to_nxt      = to_cnt;
    ube_nxt     = ube;
    is_read_nxt = is_read;
    end_rel_nxt = end_rel;
    ready_nxt   = nec_ready;
    oe_nxt      = nec_ad_oe;
    dir_nxt     = nec_ad_dir;
    ad_out_nxt  = nec_ad_out;
    req_nxt     = mem_req;
    we_nxt      = mem_we;
    io_nxt      = mem_io;
    addr_nxt    = mem_addr;
    be_nxt      = mem_be;
    wdata_nxt   = mem_wdata;
    to_err_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (astb_fall) begin
          addr_nxt  = nec_ad_in;
          io_nxt    = ~ion_s;
          ube_nxt   = ~uben_s;
          wait_nxt  = wait_states;
          to_nxt    = '0;
          state_nxt = ADDR;
        end
      end

      // RD wins when both strobes are low. Without either strobe (INTA) the
      // address phase quietly times out back to IDLE.
      ADDR: begin
        if (!rdn_s || !wrn_s) begin
          is_read_nxt = !rdn_s;
          we_nxt      = rdn_s;
          dir_nxt     = !rdn_s;
          if (rdn_s) wdata_nxt = nec_ad_in[15:0];
          ready_nxt   = 1'b0;
          req_nxt     = 1'b1;
          be_nxt      = {ube, ~mem_addr[0]};
          to_nxt      = '0;
          state_nxt   = REQ;
        end else if (to_cnt == TO_LAST) begin
          state_nxt = IDLE;
        end else begin
          to_nxt = to_cnt + 1'b1;
        end
      end

      // An acknowledge in the last allowed cycle still wins over the timeout.
      REQ: begin
        if (mem_ack) begin
          req_nxt = 1'b0;
          if (is_read) begin
            ad_out_nxt = mem_rdata;
            oe_nxt     = 1'b1;
          end
          state_nxt = WAIT;
        end else if (to_cnt == TO_LAST) begin
          to_err_nxt = 1'b1;
          req_nxt    = 1'b0;
          if (is_read) begin
            ad_out_nxt = READ_TIMEOUT_DATA;
            oe_nxt     = 1'b1;
          end
          state_nxt = WAIT;
        end else begin
          to_nxt = to_cnt + 1'b1;
        end
      end

      WAIT: begin
        if (clk_fall) begin
          if (wait_cnt == '0) begin
            ready_nxt = 1'b1;
            state_nxt = END;
          end else begin
            wait_nxt = wait_cnt - 1'b1;
          end
        end
      end

      // The driver is disabled one cycle before the direction flips so the
      // level shifter never fights the CPU.
      END: begin
        if (!end_rel) begin
          if (rdn_s && wrn_s) begin
            oe_nxt      = 1'b0;
            end_rel_nxt = 1'b1;
          end
        end else begin
          dir_nxt     = 1'b0;
          end_rel_nxt = 1'b0;
          state_nxt   = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule
